// File: rtl/n_bit_adder_pkg.sv
// Shared defaults and parameter helpers for the pipelined N-bit adder.
package n_bit_adder_pkg;

    localparam int DEFAULT_N      = 16;
    localparam int DEFAULT_STAGES = 2;

    // True when the width/stage combination splits into equal segments.
    function automatic bit params_ok(input int n, input int stages);
        return (n >= 1) && (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

    // Width of one carry segment; the divide is guarded so a bad STAGES
    // still reaches the elaboration check instead of dividing by zero.
    function automatic int seg_width(input int n, input int stages);
        return (stages > 0) ? (n / stages) : 1;
    endfunction

endpackage

// File: rtl/n_bit_adder_if.sv
// Operand/result bundle of the pipelined adder. The master drives the
// operands; the slave (the adder) drives the result.
interface n_bit_adder_if
    import n_bit_adder_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  sum, cout, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, cout, out_valid
    );
endinterface

// File: rtl/n_bit_adder_seg.sv
// Purely combinational W-bit segment adder: {co, s} = x + y + ci.
module n_bit_adder_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
endmodule

// File: rtl/n_bit_adder.sv
// Pipelined N-bit adder. The operands are cut into STAGES equal segments;
// segment k adds one cycle after segment k-1 using its registered carry.
// Upper operand bits are skewed forward and finished low sum bits are
// de-skewed so every result leaves the pipeline as a single word.
module n_bit_adder
    import n_bit_adder_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    n_bit_adder_if.slave bus
);
    localparam int W = seg_width(N, STAGES);

    if (!params_ok(N, STAGES)) begin : g_bad_params
        $error("n_bit_adder: need 1 <= STAGES <= N and N %% STAGES == 0");
    end

    logic [STAGES-1:0] vld;           // valid bit leaving stage k
    logic [STAGES-1:0] cry;           // carry leaving segment k
    logic [STAGES-1:0] stage_vld_in;  // valid bit entering stage k
    logic [STAGES-1:0] seg_ci;        // carry into segment k
    logic [STAGES-1:0] seg_co;        // carry out of segment k (combinational)
    logic [N-1:0]      sum_out;

    // Route the valid and carry of each stage into the next one.
    // NOTE: every bit is given a value before the loop, so this stays pure
    // combinational logic and no latch can be inferred.
    always_comb begin
        stage_vld_in    = '0;
        seg_ci          = '0;
        stage_vld_in[0] = bus.in_valid;
        seg_ci[0]       = bus.cin;
        for (int k = 1; k < STAGES; k++) begin
            stage_vld_in[k] = vld[k-1];
            seg_ci[k]       = cry[k-1];
        end
    end

    // Valid chain moves every cycle; a carry is captured only with its transaction.
    // NOTE: state registers use non-blocking assignments so every stage
    // samples the values from before the clock edge, not its neighbour's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            cry <= '0;
        end else begin
            vld <= stage_vld_in;
            for (int k = 0; k < STAGES; k++) begin
                if (stage_vld_in[k]) cry[k] <= seg_co[k];
            end
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_seg
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] s;
        logic [W-1:0] s_pipe [STAGES-j];

        if (j == 0) begin : g_direct
            assign x = bus.a[W-1:0];
            assign y = bus.b[W-1:0];
        end else begin : g_skew
            logic [W-1:0] a_pipe [j];
            logic [W-1:0] b_pipe [j];

            // Delay this segment's operand bits by j cycles, in step with the carry.
            // NOTE: the skew arrays are reset too, so a reset leaves no stale
            // operand anywhere in the pipeline rather than relying on valid alone.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < j; i++) begin
                        a_pipe[i] <= '0;
                        b_pipe[i] <= '0;
                    end
                end else begin
                    if (bus.in_valid) begin
                        a_pipe[0] <= bus.a[j*W +: W];
                        b_pipe[0] <= bus.b[j*W +: W];
                    end
                    for (int i = 1; i < j; i++) begin
                        if (stage_vld_in[i]) begin
                            a_pipe[i] <= a_pipe[i-1];
                            b_pipe[i] <= b_pipe[i-1];
                        end
                    end
                end
            end

            assign x = a_pipe[j-1];
            assign y = b_pipe[j-1];
        end

        n_bit_adder_seg #(.W(W)) u_seg (
            .x  (x),
            .y  (y),
            .ci (seg_ci[j]),
            .s  (s),
            .co (seg_co[j])
        );

        // Capture this segment's sum, then carry it to the output in lockstep.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < STAGES - j; i++) s_pipe[i] <= '0;
            end else begin
                if (stage_vld_in[j]) s_pipe[0] <= s;
                for (int i = 1; i < STAGES - j; i++) begin
                    if (stage_vld_in[j+i]) s_pipe[i] <= s_pipe[i-1];
                end
            end
        end

        assign sum_out[j*W +: W] = s_pipe[STAGES-j-1];
    end

    assign bus.sum       = sum_out;
    assign bus.cout      = cry[STAGES-1];
    assign bus.out_valid = vld[STAGES-1];

endmodule

// File: tb/tb_n_bit_adder.sv
// Scoreboard bench for n_bit_adder: three instances (STAGES = 1, 2, 4, N = 16)
// share one stimulus stream; each has its own expected-result queue and monitor.
module tb_n_bit_adder;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    event         drain_check;

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the full-width sum of the two operands and carry-in.
    function automatic logic [N:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + (N+1)'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ST = 1 << g;

        n_bit_adder_if #(.N(N)) bus ();
        exp_t         exp_q [$];
        logic [N-1:0] last_sum = '0;
        logic         last_cout = 1'b0;

        assign bus.in_valid = in_valid;
        assign bus.a        = a;
        assign bus.b        = b;
        assign bus.cin      = cin;

        n_bit_adder #(.N(N), .STAGES(ST)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Scoreboard push: record the expected result when a transaction is sampled.
        always @(posedge clk) begin
            if (!rst && in_valid) begin
                logic [N:0] r;
                r = ref_add(a, b, cin);
                exp_q.push_back('{sum: r[N-1:0], cout: r[N], cyc: cyc});
            end
        end

        // Outputs must clear the instant reset is asserted.
        always @(posedge rst) begin
            #1;
            check($sformatf("S%0d async rst sum", ST), 32'(bus.sum), 32'd0);
            check($sformatf("S%0d async rst cout", ST), 32'(bus.cout), 32'd0);
            check($sformatf("S%0d async rst out_valid", ST), 32'(bus.out_valid), 32'd0);
        end

        // Monitor: pop and compare on out_valid, otherwise outputs must hold.
        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                last_sum  <= '0;
                last_cout <= 1'b0;
                check($sformatf("S%0d rst sum", ST), 32'(bus.sum), 32'd0);
                check($sformatf("S%0d rst cout", ST), 32'(bus.cout), 32'd0);
                check($sformatf("S%0d rst out_valid", ST), 32'(bus.out_valid), 32'd0);
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("S%0d out_valid without issue", ST), 32'(bus.out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("S%0d sum", ST), 32'(bus.sum), 32'(e.sum));
                    check($sformatf("S%0d cout", ST), 32'(bus.cout), 32'(e.cout));
                    check($sformatf("S%0d latency", ST), 32'(cyc - e.cyc), 32'(ST));
                    last_sum  <= e.sum;
                    last_cout <= e.cout;
                end
            end else begin
                check($sformatf("S%0d hold sum", ST), 32'(bus.sum), 32'(last_sum));
                check($sformatf("S%0d hold cout", ST), 32'(bus.cout), 32'(last_cout));
            end
        end

        // Every issued transaction must have come out by the end of the run.
        always @(drain_check) begin
            check($sformatf("S%0d results outstanding", ST), 32'(exp_q.size()), 32'd0);
        end
    end

    // Present one input cycle; values are sampled at the next rising edge.
    task automatic issue(input logic v, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic tc);
        in_valid = v;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, '0, '0, 1'b0);
    endtask

    logic [N-1:0] vec_a [7] = '{16'h0002, 16'h0000, 16'h0002, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'hFFFF};
    logic [N-1:0] vec_b [7] = '{16'h0000, 16'h0002, 16'h0002, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
    logic         vec_c [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Directed vectors back-to-back, one bubble, then an all-zero add.
        for (int i = 0; i < 7; i++) issue(1'b1, vec_a[i], vec_b[i], vec_c[i]);
        idle(1);
        issue(1'b1, 16'h0000, 16'h0000, 1'b0);
        idle(6);

        // Same vectors spaced out with bubbles between them.
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, vec_a[i], vec_b[i], vec_c[i]);
            idle(i % 3);
        end
        idle(6);

        // Random traffic, biased toward carry-heavy operands.
        for (int i = 0; i < 300; i++) begin
            logic [N-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 2)) : N'($urandom);
            issue($urandom_range(0, 3) != 0, ra, rb, 1'($urandom));
        end
        idle(6);

        // Asynchronous reset with two transactions in flight.
        issue(1'b1, 16'h1234, 16'h4321, 1'b0);
        issue(1'b1, 16'hFFFF, 16'h0001, 1'b1);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);

        // Recovery after reset.
        for (int i = 0; i < 20; i++) issue(1'b1, N'($urandom), N'($urandom), 1'($urandom));
        idle(8);

        ->drain_check;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
